mcb_port_master: RTL and testbench
==================================

MCB_PORT_MASTER -- requirements
Module: mcb_port_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of cycles to wait for read data before abandoning a read.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  100MHz system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 calib_done  input  1  memory controller calibration complete.
REQ-006 req_valid  input  1  client request present.
REQ-007 req_ready  output  1  request accepted on this cycle when req_valid is also high.
REQ-008 req_we  input  1  1=write, 0=read.
REQ-009 req_addr  input  30  byte address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_be  input  4  byte enables, 1=write byte.
REQ-012 resp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-013 resp_rdata  output  32  read data, held until the next read completes.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 err  output  2  sticky flags: bit0 read timeout, bit1 rd_overflow or wr_underrun seen.
REQ-016 cmd_en / cmd_instr / cmd_bl / cmd_addr  output  1/3/6/30  MCB port-0 command FIFO push.
REQ-017 cmd_full  input  1  MCB command FIFO full.
REQ-018 wr_en / wr_mask / wr_data  output  1/4/32  MCB write FIFO push; wr_mask 1=byte masked.
REQ-019 wr_full, wr_underrun  input  1 each  MCB write FIFO status.
REQ-020 rd_en  output  1  MCB read FIFO pop.
REQ-021 rd_data  input  32  MCB read FIFO head (first-word-fall-through).
REQ-022 rd_empty, rd_overflow  input  1 each  MCB read FIFO status.

Function
REQ-023 SHALL implement states IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, DONE.
REQ-024 req_ready SHALL equal (state==IDLE) && calib_done && rd_empty.
REQ-025 On acceptance, SHALL latch addr, wdata, ~req_be and we; next state is WR_DATA if we=1, else RD_CMD.
REQ-026 cmd_addr SHALL be the latched addr with bits [1:0] forced to 0; cmd_bl SHALL always be 0 (one 32-bit word).
REQ-027 WR_DATA: wr_en = !wr_full, combinationally; on wr_en, next state is WR_CMD.
REQ-028 WR_CMD: cmd_en = !cmd_full with cmd_instr=3'b000; on cmd_en, next state is DONE.
REQ-029 RD_CMD: cmd_en = !cmd_full with cmd_instr=3'b001; on cmd_en, next state is RD_WAIT and the timer is cleared to 0.
REQ-030 RD_WAIT: rd_en = !rd_empty; on rd_en, resp_rdata <= rd_data and next state is DONE.
REQ-031 RD_WAIT with rd_empty: timer increments; when timer==TIMEOUT_CYCLES-1, SHALL set err[0], load resp_rdata=32'hDEADBEEF and go to DONE.
REQ-032 DONE: resp_valid=1 for exactly one cycle; next state is IDLE.
REQ-033 IDLE with !rd_empty (stray or late data): rd_en=1 to discard one word per cycle; no request accepted until drained.
REQ-034 cmd_en, wr_en and rd_en SHALL never be asserted in the same cycle, and SHALL never be asserted while the corresponding full/empty flag blocks them.
REQ-035 wr_underrun or rd_overflow high on any cycle SHALL set err[1]; err bits clear only on rst.
REQ-036 Minimum latency, acceptance to resp_valid: write 3 cycles, read 3 cycles plus read FIFO fill time.
REQ-037 calib_done falling mid-transaction SHALL NOT abort the transaction; it only blocks new acceptance.

Reset
REQ-038 rst SHALL asynchronously force state IDLE; req_ready, resp_valid, busy, cmd_en, wr_en and rd_en to 0; resp_rdata, err, timer and all latched fields to 0.
REQ-039 Reset mid-read SHALL rely on the IDLE drain (REQ-033) to discard late data.

Verification
REQ-040 calib_done=0, req_valid=1 -> req_ready=0, no cmd_en/wr_en for 100 cycles.
REQ-041 Write addr=0x00000106, data=0xA5A5_1234, be=4'b0011, FIFOs not full -> wr_en with wr_mask=4'b1100, next cycle cmd_en instr=000 addr=0x00000104 bl=0, next cycle resp_valid.
REQ-042 Read addr=0x10, rd_empty deasserts 5 cycles after cmd_en with rd_data=0xCAFEF00D -> rd_en one cycle, resp_valid next cycle, resp_rdata=0xCAFEF00D.
REQ-043 cmd_full held 10 cycles during WR_CMD -> cmd_en stays 0, then a single cmd_en; no duplicate wr_en.
REQ-044 Read with rd_empty stuck at 1, TIMEOUT_CYCLES=16 -> resp_valid with 0xDEADBEEF and err[0]=1; a later stray word is popped in IDLE while req_ready=0.
REQ-045 rst pulsed in RD_WAIT -> all outputs 0 immediately; after release, a pending read word is drained before req_ready rises.

Source files
------------

// File: rtl/mcb_port_master.sv
// Single-word MCB port-0 master: turns one client read/write into a command/data FIFO
// exchange, with read timeout, sticky FIFO error flags and drain of stray read data.
module mcb_port_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic [1:0]  err,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_addr,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  input  logic        wr_underrun,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  input  logic        rd_overflow
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_CMD  = 3'd2,
    RD_CMD  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        r_state;
  logic [29:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;
  logic          r_we;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_rdata;
  logic [1:0]    r_err;
  logic          w_timeout;

  // FIFO strobes react to full/empty in the same cycle; rst gates them so nothing fires in reset
  assign req_ready = !rst && (r_state == IDLE) && calib_done && rd_empty;
  assign wr_en     = !rst && (r_state == WR_DATA) && !wr_full;
  assign cmd_en    = !rst && ((r_state == WR_CMD) || (r_state == RD_CMD)) && !cmd_full;
  assign rd_en     = !rst && ((r_state == RD_WAIT) || (r_state == IDLE)) && !rd_empty;

  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign resp_rdata = r_rdata;
  assign err        = r_err;
  assign cmd_instr  = {2'b00, ~r_we};
  assign cmd_bl     = 6'd0;
  assign cmd_addr   = r_addr & ~30'h3;
  assign wr_mask    = r_mask;
  assign wr_data    = r_wdata;
  assign w_timeout  = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_we    <= 1'b0;
      r_timer <= '0;
      r_rdata <= '0;
      r_err   <= '0;
    end else begin
      if (wr_underrun || rd_overflow) r_err[1] <= 1'b1;
      case (r_state)
        IDLE: begin
          // stray words are popped by rd_en; acceptance waits until the FIFO is empty
          if (req_valid && req_ready) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= ~req_be;
            r_we    <= req_we;
            r_state <= req_we ? WR_DATA : RD_CMD;
          end
        end
        WR_DATA: if (wr_en) r_state <= WR_CMD;
        WR_CMD:  if (cmd_en) r_state <= DONE;
        RD_CMD: begin
          if (cmd_en) begin
            r_timer <= '0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_en) begin
            r_rdata <= rd_data;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_err[0] <= 1'b1;
            r_rdata  <= 32'hDEAD_BEEF;
            r_state  <= DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_port_master.sv
// Bench for mcb_port_master: directed MCB FIFO stimulus, responses checked against a
// queue of expected read data / error flags pushed at request time.
module tb_mcb_port_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        calib_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [1:0]  err;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic        cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_underrun;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_overflow;

  mcb_port_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy), .err(err),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
    .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_underrun(wr_underrun),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_overflow(rd_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt = 0;
  int   cmd_cnt = 0;
  int   rd_cnt = 0;
  int   resp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; expected response is queued at drive time
  task automatic do_req(input logic we, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic [1:0] exp_e);
    exp_t e;
    bit   ok;
    ok        = 1'b0;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (req_ready) begin
        ok      = 1'b1;
        e.rdata = exp_rd;
        e.err   = exp_e;
        sb_q.push_back(e);
      end else begin
        step();
      end
    end
    chk("req_accept", 64'(ok), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) step();
    chk(tag, 64'(busy), 64'd0);
  endtask

  // Negedge monitor: strobe counters, strobe legality, scoreboard pop on resp_valid
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wr_en)  wr_cnt++;
      if (cmd_en) cmd_cnt++;
      if (rd_en)  rd_cnt++;
      if (cmd_en || wr_en || rd_en) begin
        chk("en_excl", 64'($countones({cmd_en, wr_en, rd_en})), 64'd1);
        chk("en_blocked", 64'((cmd_en & cmd_full) | (wr_en & wr_full) | (rd_en & rd_empty)), 64'd0);
      end
      if (resp_valid) begin
        resp_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("resp_err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          c0, w0, r0, lat;
    bit          any_ready, found;

    exp_rdata = '0;
    exp_err   = '0;
    rst = 1'b1; calib_done = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    cmd_full = 1'b0; wr_full = 1'b0; wr_underrun = 1'b0;
    rd_data = '0; rd_empty = 1'b1; rd_overflow = 1'b0;

    // reset values
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_en", 64'({cmd_en, wr_en, rd_en}), 64'd0);
    rd_empty = 1'b0;
    #1;
    chk("rst_rd_en_gated", 64'(rd_en), 64'd0);
    rd_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // no acceptance without calibration
    calib_done = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    c0 = cmd_cnt; w0 = wr_cnt; any_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      any_ready |= req_ready;
      step();
    end
    chk("nocal_ready", 64'(any_ready), 64'd0);
    chk("nocal_cmd", 64'(cmd_cnt - c0), 64'd0);
    chk("nocal_wr", 64'(wr_cnt - w0), 64'd0);
    req_valid = 1'b0; calib_done = 1'b1;

    // basic write
    do_req(1'b1, 30'h106, 32'hA5A5_1234, 4'b0011, exp_rdata, exp_err);
    #1;
    chk("w1_wr_en", 64'(wr_en), 64'd1);
    chk("w1_wr_mask", 64'(wr_mask), 64'hC);
    chk("w1_wr_data", 64'(wr_data), 64'hA5A5_1234);
    chk("w1_cmd_en0", 64'(cmd_en), 64'd0);
    step(); #1;
    chk("w1_cmd_en", 64'(cmd_en), 64'd1);
    chk("w1_cmd_instr", 64'(cmd_instr), 64'd0);
    chk("w1_cmd_addr", 64'(cmd_addr), 64'h104);
    chk("w1_cmd_bl", 64'(cmd_bl), 64'd0);
    chk("w1_wr_en0", 64'(wr_en), 64'd0);
    step(); #1;
    chk("w1_resp_valid", 64'(resp_valid), 64'd1);
    step();
    chk("w1_idle", 64'(busy), 64'd0);

    // write with wr_full then cmd_full back-pressure
    wr_full = 1'b1;
    do_req(1'b1, 30'h200, 32'hDEAD_0001, 4'b1111, exp_rdata, exp_err);
    w0 = wr_cnt;
    repeat (3) step();
    chk("w2_wrfull_hold", 64'(wr_cnt - w0), 64'd0);
    wr_full = 1'b0; cmd_full = 1'b1;
    #1;
    chk("w2_wr_en", 64'(wr_en), 64'd1);
    chk("w2_wr_mask", 64'(wr_mask), 64'h0);
    step();
    c0 = cmd_cnt; w0 = wr_cnt;
    repeat (10) step();
    chk("w2_cmdfull_hold", 64'(cmd_cnt - c0), 64'd0);
    cmd_full = 1'b0;
    #1;
    chk("w2_cmd_en", 64'(cmd_en), 64'd1);
    wait_idle("w2_idle", 10);
    chk("w2_single_cmd", 64'(cmd_cnt - c0), 64'd1);
    chk("w2_no_dup_wr", 64'(wr_cnt - w0), 64'd0);

    // read, data arrives 5 cycles after cmd_en
    exp_rdata = 32'hCAFE_F00D;
    do_req(1'b0, 30'h10, 32'h0, 4'h0, exp_rdata, exp_err);
    #1;
    chk("r1_cmd_en", 64'(cmd_en), 64'd1);
    chk("r1_cmd_instr", 64'(cmd_instr), 64'd1);
    chk("r1_cmd_addr", 64'(cmd_addr), 64'h10);
    step();
    repeat (4) step();
    r0 = rd_cnt;
    rd_data = 32'hCAFE_F00D; rd_empty = 1'b0;
    #1;
    chk("r1_rd_en", 64'(rd_en), 64'd1);
    step();
    rd_empty = 1'b1; rd_data = '0;
    #1;
    chk("r1_resp_valid", 64'(resp_valid), 64'd1);
    chk("r1_rd_once", 64'(rd_cnt - r0), 64'd1);
    wait_idle("r1_idle", 5);

    // read at minimum latency
    exp_rdata = 32'h0BAD_F00D;
    do_req(1'b0, 30'h24, 32'h0, 4'h0, exp_rdata, exp_err);
    rd_data = 32'h0BAD_F00D; rd_empty = 1'b0;
    #1;
    chk("r2_cmd_en", 64'(cmd_en), 64'd1);
    chk("r2_rd_en0", 64'(rd_en), 64'd0);
    step(); #1;
    chk("r2_rd_en", 64'(rd_en), 64'd1);
    step();
    rd_empty = 1'b1; rd_data = '0;
    #1;
    chk("r2_resp_valid", 64'(resp_valid), 64'd1);
    wait_idle("r2_idle", 5);

    // read timeout: RD_CMD cycle + 16 wait cycles, response on cycle 18
    exp_rdata = 32'hDEAD_BEEF; exp_err = 2'b01;
    do_req(1'b0, 30'h40, 32'h0, 4'h0, exp_rdata, exp_err);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      #1;
      if (resp_valid) begin
        found = 1'b1;
        lat = i;
      end else begin
        step();
      end
    end
    chk("to_seen", 64'(found), 64'd1);
    chk("to_latency", 64'(lat), 64'd18);
    step();
    rd_data = 32'h1111_2222; rd_empty = 1'b0;
    #1;
    chk("stray_ready", 64'(req_ready), 64'd0);
    chk("stray_rd_en", 64'(rd_en), 64'd1);
    chk("stray_busy", 64'(busy), 64'd0);
    step();
    rd_empty = 1'b1;
    #1;
    chk("stray_ready_after", 64'(req_ready), 64'd1);
    chk("stray_err", 64'(err), 64'h1);
    chk("stray_rdata_kept", 64'(resp_rdata), 64'hDEAD_BEEF);

    // overflow flag is sticky
    rd_overflow = 1'b1;
    step();
    rd_overflow = 1'b0;
    repeat (2) step();
    chk("ovf_err", 64'(err), 64'h3);

    // reset while waiting for read data, then drain the late word
    do_req(1'b0, 30'h80, 32'h0, 4'h0, exp_rdata, exp_err);
    step(); step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_rdata", 64'(resp_rdata), 64'd0);
    chk("mid_rst_en", 64'({cmd_en, wr_en, rd_en}), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_resp", 64'(resp_valid), 64'd0);
    sb_q.delete();
    exp_rdata = '0; exp_err = '0;
    rd_data = 32'h7777_8888; rd_empty = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("drain_ready", 64'(req_ready), 64'd0);
    chk("drain_rd_en", 64'(rd_en), 64'd1);
    step();
    rd_empty = 1'b1;
    #1;
    chk("drain_ready_after", 64'(req_ready), 64'd1);

    // write at the top address with a single byte enabled
    do_req(1'b1, 30'h3FFF_FFFF, 32'h0F0F_0F0F, 4'b1000, exp_rdata, exp_err);
    #1;
    chk("w3_wr_mask", 64'(wr_mask), 64'h7);
    step(); #1;
    chk("w3_cmd_addr", 64'(cmd_addr), 64'h3FFF_FFFC);
    wait_idle("w3_idle", 5);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("resp_count", 64'(resp_cnt), 64'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
